// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and constants.
// Reset PC, stall bit map, FSM encoding, IF->ID bundle, PC helpers.
package fetch_stage_pkg;

  localparam int PC_W    = 64;
  localparam int STALL_W = 6;

  localparam logic [PC_W-1:0] RESET_PC_DEF =
    64'h0000_0000_8000_0000;

  localparam int STALL_IF  = 0;
  localparam int STALL_ID  = 1;
  localparam int STALL_EX  = 2;
  localparam int STALL_MEM = 3;
  localparam int STALL_DC  = 4;
  localparam int STALL_WB  = 5;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic            pc_valid;
    logic [PC_W-1:0] pc;
  } if_id_t;

  function automatic logic [PC_W-1:0] word_align(
    input logic [PC_W-1:0] a
  );
    return a & ~PC_W'(3);
  endfunction

  function automatic logic [PC_W-1:0] dw_align(
    input logic [PC_W-1:0] a
  );
    return a & ~PC_W'(7);
  endfunction

  function automatic logic is_misaligned(
    input logic [PC_W-1:0] a
  );
    return (a & PC_W'(3)) != '0;
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating fetch and redirect performance counters.
// Ports: clk, rst, inc_fetch, inc_redirect -> fetch_cnt, redirect_cnt.
module fetch_perf_cnt #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_fetch,
  input  logic             inc_redirect,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic fetch_sat;
  logic redir_sat;

  assign fetch_sat = &fetch_cnt;
  assign redir_sat = &redirect_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (inc_fetch && !fetch_sat)
        fetch_cnt <= fetch_cnt + ONE;
      if (inc_redirect && !redir_sat)
        redirect_cnt <= redirect_cnt + ONE;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, drives the I-SRAM.
// Ports: clk, rst, stall, br_e/br_addr in; pc/pc_valid, sram, excp, counters out.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              CNT_W    = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               br_e,
  input  logic [PC_W-1:0]    br_addr,
  output logic               pc_valid,
  output logic [PC_W-1:0]    pc,
  output logic               inst_sram_en,
  output logic [PC_W-1:0]    inst_sram_addr,
  output logic               excp_misalign,
  output logic [PC_W-1:0]    excp_badaddr,
  output logic [CNT_W-1:0]   fetch_cnt,
  output logic [CNT_W-1:0]   redirect_cnt
);

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic            run;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            take_br;
  logic            advance;
  logic            br_mis;
  logic            mis_q;
  logic [PC_W-1:0] bad_q;
  if_id_t          to_id;
  logic            unused_stall;

  // Only the IF hold bit matters here.
  assign unused_stall = ^stall[STALL_WB:STALL_ID];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= BOOT;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN:  state_d = RUN;
    endcase
  end

  always_comb begin
    run          = (state_q == RUN);
    to_id        = '{pc_valid: run, pc: pc_q};
    pc_valid     = to_id.pc_valid;
    pc           = to_id.pc;
    inst_sram_en = run;
  end

  // Redirect wins over stall so a taken branch is never dropped.
  assign take_br = run & br_e;
  assign advance = run & ~br_e & ~stall[STALL_IF];
  assign br_mis  = take_br & is_misaligned(br_addr);

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      take_br: pc_d = word_align(br_addr);
      advance: pc_d = pc_q + PC_W'(4);
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc_q <= RESET_PC;
    else
      pc_q <= pc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
      bad_q <= '0;
    end else begin
      mis_q <= br_mis;
      if (br_mis)
        bad_q <= br_addr;
    end
  end

  // Stalls keep re-reading the same doubleword so SRAM data stays put.
  assign inst_sram_addr = dw_align(pc_q);
  assign excp_misalign  = mis_q;
  assign excp_badaddr   = bad_q;

  fetch_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk         (clk),
    .rst         (rst),
    .inc_fetch   (advance),
    .inc_redirect(take_br),
    .fetch_cnt   (fetch_cnt),
    .redirect_cnt(redirect_cnt)
  );

endmodule
